// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock-enable divider.
// Optional feature macro: CLK_DIV_CTRL_SYNC_EN (adds the sync_req port).
package clk_div_pkg;

    localparam int DEF_CNT_W    = 8;
    localparam int DEF_NCH      = 2;
    localparam int DEF_DIV0_RST = 2;
    localparam int DEF_DIV1_RST = 4;

    typedef logic [$clog2(DEF_NCH)-1:0] ch_idx_t;

    // Default-width layout of one channel's state; clk_div_chan keeps the
    // same fields at its own CNT_W.
    typedef struct packed {
        logic [DEF_CNT_W-1:0] cnt;
        logic [DEF_CNT_W-1:0] hp;
        logic                 en;
        logic                 lvl;
        logic [DEF_CNT_W-1:0] p_div;
        logic                 p_en;
        logic                 pend;
    } chan_state_t;

    // Channel 0 has its own reset half-period, every other channel shares one.
    function automatic int rst_div(input int ch, input int div0, input int div1);
        return (ch == 0) ? div0 : div1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, level toggle, edge pulses and a
// single-entry pending update slot applied at the falling toggle.
// Optional feature macro: CLK_DIV_CTRL_SYNC_EN (adds the sync_req port).
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W  = DEF_CNT_W,
    parameter logic [CNT_W-1:0] HP_RST = '0
) (
    input  logic             clk_in,
    input  logic             resetn,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_en,
`ifdef CLK_DIV_CTRL_SYNC_EN
    input  logic             sync_req,
`endif
    output logic             clk_out,
    output logic             rise_pls,
    output logic             fall_pls,
    output logic             pending
);

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] hp;
        logic             en;
        logic             lvl;
        logic [CNT_W-1:0] p_div;
        logic             p_en;
        logic             pend;
    } chan_reg_t;

    chan_reg_t st;
    logic      rise_q;
    logic      fall_q;

    // Counter/toggle state machine; updates are held until the falling
    // toggle so a phase is never cut short, and an idle channel loads directly.
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            st     <= '{cnt: '0, hp: HP_RST, en: 1'b1, lvl: 1'b0,
                        p_div: '0, p_en: 1'b0, pend: 1'b0};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
`ifdef CLK_DIV_CTRL_SYNC_EN
            if (sync_req && st.en) begin
                st.cnt <= '0;
                st.lvl <= 1'b0;
                fall_q <= st.lvl;
                if (st.pend) begin
                    st.hp   <= st.p_div;
                    st.en   <= st.p_en;
                    st.pend <= 1'b0;
                end
            end else
`endif
            if (st.en) begin
                if (st.cnt == st.hp) begin
                    st.cnt <= '0;
                    st.lvl <= !st.lvl;
                    rise_q <= !st.lvl;
                    fall_q <= st.lvl;
                    if (st.lvl && st.pend) begin
                        st.hp   <= st.p_div;
                        st.en   <= st.p_en;
                        st.pend <= 1'b0;
                    end
                end else begin
                    st.cnt <= st.cnt + 1'b1;
                end
                if (cfg_we) begin
                    st.p_div <= cfg_div;
                    st.p_en  <= cfg_en;
                    st.pend  <= 1'b1;
                end
            end else if (cfg_we) begin
                st.hp <= cfg_div;
                st.en <= cfg_en;
            end
        end
    end

    assign clk_out  = st.lvl;
    assign rise_pls = rise_q;
    assign fall_pls = fall_q;
    assign pending  = st.pend;

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider controller: NCH independent channels
// with a shared valid/ready configuration port.
// Optional feature macro: CLK_DIV_CTRL_SYNC_EN (adds sync_req, which
// realigns all enabled channels and blocks configuration for that cycle).
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int NCH      = DEF_NCH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DIV0_RST = DEF_DIV0_RST,
    parameter int DIV1_RST = DEF_DIV1_RST
) (
    input  logic                    clk_in,
    input  logic                    resetn,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [$clog2(NCH)-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]        cfg_div,
    input  logic                    cfg_en,
`ifdef CLK_DIV_CTRL_SYNC_EN
    input  logic                    sync_req,
`endif
    output logic [NCH-1:0]          clk_out,
    output logic [NCH-1:0]          rise_pls,
    output logic [NCH-1:0]          fall_pls,
    output logic [NCH-1:0]          pending
);

    localparam int CH_W = $clog2(NCH);

    // Ready follows the pending flag of the addressed channel; a sync cycle
    // refuses all configuration so it cannot race the forced apply.
    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending[i];
            end
        end
`ifdef CLK_DIV_CTRL_SYNC_EN
        if (sync_req) begin
            cfg_ready = 1'b0;
        end
`endif
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        localparam int HP_INT = rst_div(g, DIV0_RST, DIV1_RST);

        logic ch_we;
        assign ch_we = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        clk_div_chan #(
            .CNT_W  (CNT_W),
            .HP_RST (CNT_W'(HP_INT))
        ) u_chan (
            .clk_in   (clk_in),
            .resetn   (resetn),
            .cfg_we   (ch_we),
            .cfg_div  (cfg_div),
            .cfg_en   (cfg_en),
`ifdef CLK_DIV_CTRL_SYNC_EN
            .sync_req (sync_req),
`endif
            .clk_out  (clk_out[g]),
            .rise_pls (rise_pls[g]),
            .fall_pls (fall_pls[g]),
            .pending  (pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// timestamp-based model of each channel.
module tb_clk_div_ctrl;

    localparam int NCH   = 2;
    localparam int CNT_W = 8;

    logic             clk_in = 1'b0;
    logic             resetn;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [0:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_en;
    logic             sync_req;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   rise_pls;
    logic [NCH-1:0]   fall_pls;
    logic [NCH-1:0]   pending;

    int checks   = 0;
    int failures = 0;

    clk_div_ctrl #(.NCH(NCH), .CNT_W(CNT_W), .DIV0_RST(2), .DIV1_RST(4)) dut (
        .clk_in    (clk_in),
        .resetn    (resetn),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
`ifdef CLK_DIV_CTRL_SYNC_EN
        .sync_req  (sync_req),
`endif
        .clk_out   (clk_out),
        .rise_pls  (rise_pls),
        .fall_pls  (fall_pls),
        .pending   (pending)
    );

    always #5 clk_in = ~clk_in;

    // Model: each running channel has a scheduled edge-number for its next toggle.
    int t;
    int m_hp   [NCH];
    bit m_en   [NCH];
    bit m_lvl  [NCH];
    int m_next [NCH];
    bit m_pend [NCH];
    int m_pdiv [NCH];
    bit m_pen  [NCH];
    bit m_rise [NCH];
    bit m_fall [NCH];
    bit m_sync;
    bit m_acc;

    always @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            t = 0;
            for (int c = 0; c < NCH; c++) begin
                m_hp[c]   = (c == 0) ? 2 : 4;
                m_en[c]   = 1'b1;
                m_lvl[c]  = 1'b0;
                m_next[c] = m_hp[c] + 1;
                m_pend[c] = 1'b0;
                m_pdiv[c] = 0;
                m_pen[c]  = 1'b0;
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
            end
        end else begin
            t++;
`ifdef CLK_DIV_CTRL_SYNC_EN
            m_sync = sync_req;
`else
            m_sync = 1'b0;
`endif
            m_acc = cfg_valid && !m_sync && !m_pend[int'(cfg_ch)];
            for (int c = 0; c < NCH; c++) begin
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (m_sync && m_en[c]) begin
                    m_fall[c] = m_lvl[c];
                    m_lvl[c]  = 1'b0;
                    if (m_pend[c]) begin
                        m_hp[c]   = m_pdiv[c];
                        m_en[c]   = m_pen[c];
                        m_pend[c] = 1'b0;
                    end
                    m_next[c] = t + m_hp[c] + 1;
                end else if (m_en[c]) begin
                    if (t == m_next[c]) begin
                        m_lvl[c] = !m_lvl[c];
                        if (m_lvl[c]) begin
                            m_rise[c] = 1'b1;
                        end else begin
                            m_fall[c] = 1'b1;
                            if (m_pend[c]) begin
                                m_hp[c]   = m_pdiv[c];
                                m_en[c]   = m_pen[c];
                                m_pend[c] = 1'b0;
                            end
                        end
                        m_next[c] = t + m_hp[c] + 1;
                    end
                    if (m_acc && int'(cfg_ch) == c) begin
                        m_pdiv[c] = int'(cfg_div);
                        m_pen[c]  = cfg_en;
                        m_pend[c] = 1'b1;
                    end
                end else if (m_acc && int'(cfg_ch) == c) begin
                    m_hp[c]   = int'(cfg_div);
                    m_en[c]   = cfg_en;
                    m_next[c] = t + m_hp[c] + 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input int ch, input int div, input bit en);
        cfg_valid = v;
        cfg_ch    = 1'(ch);
        cfg_div   = CNT_W'(div);
        cfg_en    = en;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Counts edges until the requested pulse appears; -1 if it never does.
    task automatic waitPulse(input int ch, input bit rise, output int edges);
        edges = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if ((rise ? rise_pls[ch] : fall_pls[ch]) === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic waitIdlePending(input int ch);
        for (int k = 0; k < 100 && pending[ch] !== 1'b0; k++) begin
            tick();
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    logic [NCH-1:0] e_clk, e_rise, e_fall, e_pend;
    logic           e_rdy;
    always @(negedge clk_in) begin
        for (int c = 0; c < NCH; c++) begin
            e_clk[c]  = m_lvl[c];
            e_rise[c] = m_rise[c];
            e_fall[c] = m_fall[c];
            e_pend[c] = m_pend[c];
        end
        e_rdy = !m_pend[int'(cfg_ch)];
`ifdef CLK_DIV_CTRL_SYNC_EN
        if (sync_req) e_rdy = 1'b0;
`endif
        checkOutput("model_clk_out",  32'(clk_out),  32'(e_clk));
        checkOutput("model_rise_pls", 32'(rise_pls), 32'(e_rise));
        checkOutput("model_fall_pls", 32'(fall_pls), 32'(e_fall));
        checkOutput("model_pending",  32'(pending),  32'(e_pend));
        checkOutput("model_cfg_ready", 32'(cfg_ready), 32'(e_rdy));
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    int e;
    int r;
    int bad;
    initial begin
        resetn   = 1'b0;
        sync_req = 1'b0;
        applyStimulus(0, 0, 0, 1);
        #23;
        checkOutput("reset_clk_out", 32'(clk_out), 0);
        checkOutput("reset_pulses", 32'(rise_pls | fall_pls), 0);
        checkOutput("reset_pending", 32'(pending), 0);
        checkOutput("reset_ready", 32'(cfg_ready), 1);
        @(negedge clk_in);
        resetn = 1'b1;

        // Defaults: first rise on edge 3, periods 6 and 10.
        waitPulse(0, 1, e);
        checkOutput("first_rise0", e, 3);
        waitPulse(0, 1, e);
        checkOutput("period0_default", e, 6);
        waitPulse(1, 1, e);
        waitPulse(1, 1, e);
        checkOutput("period1_default", e, 10);

        // Divide-by-2 update deferred to the falling toggle.
        applyStimulus(1, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        checkOutput("pend0_after_write", 32'(pending[0]), 1);
        waitPulse(0, 0, e);
        checkOutput("pend0_cleared", 32'(pending[0]), 0);
        waitPulse(0, 1, e);
        waitPulse(0, 1, e);
        checkOutput("period0_div2", e, 2);

        // Back-pressure on ch0 while ch1 stays writable.
        applyStimulus(1, 0, 3, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        waitPulse(0, 0, e);
        applyStimulus(1, 0, 1, 1);
        tick();
        checkOutput("pend0_second", 32'(pending[0]), 1);
        applyStimulus(1, 0, 2, 1);
        #1;
        checkOutput("ready0_blocked", 32'(cfg_ready), 0);
        tick();
        tick();
        checkOutput("ready0_still_blocked", 32'(cfg_ready), 0);
        applyStimulus(1, 1, 4, 1);
        #1;
        checkOutput("ready1_open", 32'(cfg_ready), 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        checkOutput("pend1_accepted", 32'(pending[1]), 1);
        waitPulse(0, 0, e);
        waitPulse(0, 1, e);
        waitPulse(0, 1, e);
        checkOutput("period0_hp1_not_hp2", e, 4);

        // Disable ch1 mid-high, then re-enable with hp=3.
        waitIdlePending(1);
        waitPulse(1, 1, e);
        applyStimulus(1, 1, 4, 0);
        tick();
        applyStimulus(0, 0, 0, 1);
        waitPulse(1, 0, e);
        checkOutput("ch1_full_high_before_park", (e < 0) ? -1 : e + 1, 5);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (clk_out[1] || rise_pls[1] || fall_pls[1]) bad++;
        end
        checkOutput("ch1_parked_quiet", bad, 0);
        applyStimulus(1, 1, 3, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        waitPulse(1, 1, e);
        checkOutput("ch1_reenable_first_rise", e, 4);

        // Asynchronous reset with an update pending.
        applyStimulus(1, 0, 5, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        checkOutput("pend0_before_reset", 32'(pending[0]), 1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async_reset_clk_out", 32'(clk_out), 0);
        checkOutput("async_reset_pulses", 32'(rise_pls | fall_pls), 0);
        checkOutput("async_reset_pending", 32'(pending), 0);
        repeat (3) @(negedge clk_in);
        resetn = 1'b1;
        waitPulse(0, 1, e);
        checkOutput("rise0_after_reset", e, 3);
        waitPulse(0, 1, e);
        checkOutput("period0_after_reset", e, 6);

        // Randomized traffic, including occasional resets and syncs.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 3) == 0, $urandom % 2, $urandom % 6, ($urandom % 5) != 0);
`ifdef CLK_DIV_CTRL_SYNC_EN
            sync_req = ($urandom % 50) == 0;
`endif
            if (($urandom % 700) == 0) begin
                resetn = 1'b0;
                #3;
                resetn = 1'b1;
            end
            tick();
        end
        applyStimulus(0, 0, 0, 1);
        sync_req = 1'b0;

`ifdef CLK_DIV_CTRL_SYNC_EN
        // Align both channels at hp=1 with a sync pulse.
        waitIdlePending(0);
        applyStimulus(1, 0, 1, 1);
        tick();
        waitIdlePending(1);
        applyStimulus(1, 1, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        waitIdlePending(0);
        waitIdlePending(1);
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        bad = 0;
        r = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (rise_pls[0] !== rise_pls[1]) bad++;
            if (rise_pls[0]) r++;
        end
        checkOutput("sync_rise_aligned", bad, 0);
        checkOutput("sync_rise_count", r, 5);
`endif

        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
